// File: rtl/bus_stop_monitor.sv
// Run-control monitor: snoops bus writes against watch addresses and raises Done or Timeout.
// Optional first-hit trace capture is enabled by defining BUS_STOP_MON_TRACE_EN.
module bus_stop_monitor #(
  parameter int                        ADDR_W         = 16,
  parameter int                        DATA_W         = 16,
  parameter int                        NUM_CH         = 2,
  parameter logic [NUM_CH*ADDR_W-1:0]  WATCH_ADDRS    = {16'd1025, 16'd1024},
  parameter logic [DATA_W-1:0]         WATCH_VALUE    = 16'hFFFF,
  parameter bit                        MATCH_ALL      = 1'b1,
  parameter int                        CNT_W          = 32,
  parameter int unsigned               TIMEOUT_CYCLES = 0
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data,
  input  logic              nME,
  input  logic              RnW,
  input  logic              Clear,
  output logic              Done,
  output logic              Timeout,
  output logic [NUM_CH-1:0] HitMask,
  output logic [CNT_W-1:0]  CycleCount,
  output logic [2:0]        FirstHitCh,
  output logic [DATA_W-1:0] FirstHitData
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DONE    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic              wrStb;
  logic              wrStbQ;
  logic              wrEvent;
  logic [NUM_CH-1:0] hitVec;
  logic [NUM_CH-1:0] hitMaskNext;
  logic              patternMet;
  logic              budgetOut;

  // One event per write strobe, taken on its first cycle.
  assign wrStb   = !nME && !RnW;
  assign wrEvent = wrStb && !wrStbQ;

  always_comb begin
    hitVec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hitVec[i] = wrEvent
                  && (Address == WATCH_ADDRS[i*ADDR_W +: ADDR_W])
                  && (Data == WATCH_VALUE);
    end
  end

  // The mask keeps accumulating after a timeout but is frozen once the stop condition is met.
  assign hitMaskNext = (state == ST_DONE) ? HitMask : (HitMask | hitVec);
  assign patternMet  = MATCH_ALL ? (&hitMaskNext) : (|hitMaskNext);
  assign budgetOut   = TIMEOUT_EN && (CycleCount == TO_LAST);

  always_comb begin
    stateNext = state;
    if (state == ST_RUN) begin
      if (patternMet) begin
        stateNext = ST_DONE;
      end else if (budgetOut) begin
        stateNext = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= ST_RUN;
      wrStbQ     <= 1'b0;
      HitMask    <= '0;
      CycleCount <= '0;
    end else begin
      wrStbQ <= wrStb;
      if (Clear) begin
        state      <= ST_RUN;
        HitMask    <= '0;
        CycleCount <= '0;
      end else begin
        state   <= stateNext;
        HitMask <= hitMaskNext;
        if ((state == ST_RUN) && (CycleCount != CNT_MAX)) begin
          CycleCount <= CycleCount + CNT_W'(1);
        end
      end
    end
  end

  assign Done    = (state == ST_DONE);
  assign Timeout = (state == ST_TIMEOUT);

`ifdef BUS_STOP_MON_TRACE_EN
  logic [2:0] lowestHit;

  always_comb begin
    lowestHit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hitVec[i]) begin
        lowestHit = 3'(i);
      end
    end
  end

  // An empty mask outside DONE means no hit has been seen since reset or Clear.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      FirstHitCh   <= '0;
      FirstHitData <= '0;
    end else if (Clear) begin
      FirstHitCh   <= '0;
      FirstHitData <= '0;
    end else if ((state != ST_DONE) && (HitMask == '0) && (|hitVec)) begin
      FirstHitCh   <= lowestHit;
      FirstHitData <= Data;
    end
  end
`else
  assign FirstHitCh   = '0;
  assign FirstHitData = '0;
`endif

endmodule

// File: tb/tb_bus_stop_monitor.sv
// Directed self-checking bench for bus_stop_monitor; four instances cover the
// match-all, match-any and two timeout configurations on a shared bus.
module tb_bus_stop_monitor;

  logic        Clock;
  logic        nReset;
  logic [15:0] Address;
  logic [15:0] Data;
  logic        nME;
  logic        RnW;
  logic        Clear;

  logic        doneA, doneB, doneC, doneD;
  logic        timeoutA, timeoutB, timeoutC, timeoutD;
  logic [1:0]  hitA, hitB, hitC, hitD;
  logic [31:0] cntA, cntB, cntC, cntD;
  logic [2:0]  fhChA, fhChB, fhChC, fhChD;
  logic [15:0] fhDataA, fhDataB, fhDataC, fhDataD;

  int checkCount = 0;
  int failCount  = 0;

`ifdef BUS_STOP_MON_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  bus_stop_monitor dutA (
    .Clock(Clock), .nReset(nReset), .Address(Address), .Data(Data), .nME(nME), .RnW(RnW),
    .Clear(Clear), .Done(doneA), .Timeout(timeoutA), .HitMask(hitA), .CycleCount(cntA),
    .FirstHitCh(fhChA), .FirstHitData(fhDataA)
  );

  bus_stop_monitor #(.MATCH_ALL(1'b0)) dutB (
    .Clock(Clock), .nReset(nReset), .Address(Address), .Data(Data), .nME(nME), .RnW(RnW),
    .Clear(Clear), .Done(doneB), .Timeout(timeoutB), .HitMask(hitB), .CycleCount(cntB),
    .FirstHitCh(fhChB), .FirstHitData(fhDataB)
  );

  bus_stop_monitor #(.TIMEOUT_CYCLES(100)) dutC (
    .Clock(Clock), .nReset(nReset), .Address(Address), .Data(Data), .nME(nME), .RnW(RnW),
    .Clear(Clear), .Done(doneC), .Timeout(timeoutC), .HitMask(hitC), .CycleCount(cntC),
    .FirstHitCh(fhChC), .FirstHitData(fhDataC)
  );

  bus_stop_monitor #(.TIMEOUT_CYCLES(10)) dutD (
    .Clock(Clock), .nReset(nReset), .Address(Address), .Data(Data), .nME(nME), .RnW(RnW),
    .Clear(Clear), .Done(doneD), .Timeout(timeoutD), .HitMask(hitD), .CycleCount(cntD),
    .FirstHitCh(fhChD), .FirstHitData(fhDataD)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Every task is entered and left 1 time unit after a rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic busIdle();
    nME = 1'b1;
    RnW = 1'b1;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [15:0] data, input int len);
    busIdle();
    tick();
    Address = addr;
    Data    = data;
    nME     = 1'b0;
    RnW     = 1'b0;
    repeat (len) tick();
    busIdle();
  endtask

  task automatic busRead(input logic [15:0] addr, input logic [15:0] data);
    busIdle();
    tick();
    Address = addr;
    Data    = data;
    nME     = 1'b0;
    RnW     = 1'b1;
    tick();
    busIdle();
  endtask

  task automatic doClear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  task automatic applyStimulus();
    // Reset state
    #3;
    checkOutput("rst done", doneA, 0);
    checkOutput("rst timeout", timeoutA, 0);
    checkOutput("rst hitmask", hitA, 0);
    checkOutput("rst count", cntA, 0);
    checkOutput("rst firstch", fhChA, 0);
    checkOutput("rst firstdata", fhDataA, 0);
    #9;
    nReset = 1'b1;

    // Match-all: two hits complete the pattern; match-any freezes after its first hit
    busWrite(16'd1024, 16'hFFFF, 1);
    checkOutput("t1 hit1 mask", hitA, 2'b01);
    checkOutput("t1 hit1 done", doneA, 0);
    busWrite(16'd1025, 16'hFFFF, 1);
    checkOutput("t1 hit2 mask", hitA, 2'b11);
    checkOutput("t1 hit2 done", doneA, 1);
    checkOutput("t1 count", cntA, 4);
    checkOutput("t1 any frozen mask", hitB, 2'b01);
    repeat (3) tick();
    checkOutput("t1 count frozen", cntA, 4);
    checkOutput("t1 done sticky", doneA, 1);

    // Match-any on channel 1, then trace of a ch1-first sequence
    doClear();
    checkOutput("t2 clr mask", hitB, 0);
    checkOutput("t2 clr done", doneB, 0);
    checkOutput("t2 clr firstch", fhChA, 0);
    busWrite(16'd1025, 16'hFFFF, 1);
    checkOutput("t2 any mask", hitB, 2'b10);
    checkOutput("t2 any done", doneB, 1);
    checkOutput("t2 all done early", doneA, 0);
    busWrite(16'd1024, 16'hFFFF, 1);
    checkOutput("t2 any mask held", hitB, 2'b10);
    checkOutput("t2 all done", doneA, 1);
    checkOutput("t6 firstch", fhChA, TRACE ? 3'd1 : 3'd0);
    checkOutput("t6 firstdata", fhDataA, TRACE ? 16'hFFFF : 16'h0000);

    // Wrong data, a read, then a long strobe that must count once
    doClear();
    busWrite(16'd1024, 16'h1234, 1);
    checkOutput("t3 wrong data mask", hitA, 2'b00);
    busRead(16'd1024, 16'hFFFF);
    checkOutput("t3 read mask", hitA, 2'b00);
    checkOutput("t3 read firstdata", fhDataA, 0);
    busWrite(16'd1024, 16'hFFFF, 4);
    checkOutput("t3 long strobe mask", hitA, 2'b01);
    checkOutput("t3 long strobe done", doneA, 0);
    checkOutput("t3 count", cntA, 9);
    checkOutput("t3 firstch", fhChA, 0);
    checkOutput("t3 firstdata", fhDataA, TRACE ? 16'hFFFF : 16'h0000);

    // A write event coinciding with Clear is discarded
    tick();
    Address = 16'd1025;
    Data    = 16'hFFFF;
    Clear   = 1'b1;
    nME     = 1'b0;
    RnW     = 1'b0;
    tick();
    Clear = 1'b0;
    busIdle();
    tick();
    checkOutput("clear write mask", hitA, 2'b00);
    checkOutput("clear write count", cntA, 1);

    // Timeout budget of 100 cycles
    doClear();
    repeat (99) tick();
    checkOutput("t4 count 99", cntC, 99);
    checkOutput("t4 no timeout yet", timeoutC, 0);
    tick();
    checkOutput("t4 timeout", timeoutC, 1);
    checkOutput("t4 count 100", cntC, 100);
    checkOutput("t4 done", doneC, 0);
    busWrite(16'd1024, 16'hFFFF, 1);
    checkOutput("t4 mask in timeout", hitC, 2'b01);
    checkOutput("t4 count frozen", cntC, 100);
    checkOutput("t4 timeout sticky", timeoutC, 1);

    // Pattern completes on the same edge the 10-cycle budget runs out
    doClear();
    busWrite(16'd1024, 16'hFFFF, 1);
    repeat (6) tick();
    checkOutput("t5 count 8", cntD, 8);
    busWrite(16'd1025, 16'hFFFF, 1);
    checkOutput("t5 done", doneD, 1);
    checkOutput("t5 timeout", timeoutD, 0);
    checkOutput("t5 count 10", cntD, 10);
    repeat (2) tick();
    checkOutput("t5 timeout held", timeoutD, 0);
    checkOutput("t5 count frozen", cntD, 10);
    doClear();
    checkOutput("t5 clr done", doneD, 0);
    checkOutput("t5 clr mask", hitD, 0);
    checkOutput("t5 clr count", cntD, 0);
    busWrite(16'd1024, 16'hFFFF, 1);
    checkOutput("t5 run resumes count", cntD, 2);
    checkOutput("t5 run resumes mask", hitD, 2'b01);

    // Asynchronous reset mid-run
    nReset = 1'b0;
    #2;
    checkOutput("t5 async mask", hitD, 0);
    checkOutput("t5 async count", cntD, 0);
    checkOutput("t5 async done", doneD, 0);
    checkOutput("t5 async all done", doneA, 0);
    checkOutput("t5 async firstdata", fhDataA, 0);
    #1;
    nReset = 1'b1;
    tick();
    checkOutput("post reset count", cntD, 1);
  endtask

  initial begin
    nReset  = 1'b0;
    Clear   = 1'b0;
    Address = '0;
    Data    = '0;
    busIdle();
    applyStimulus();
    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
